// File: rtl/router_dest_reader_pkg.sv
// Shared router definitions: header layout, byte width and reader FSM encodings.
// A header byte is {len[5:0], addr[1:0]}; the packet is the header, len payload bytes, then one parity byte.
package router_dest_reader_pkg;
  localparam int BYTE_W   = 8;
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;
  localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;
  localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_HDR  = 3'd2,
    ST_BODY = 3'd3,
    ST_DONE = 3'd4
  } rd_state_t;

  function automatic hdr_t unpack_hdr(input logic [BYTE_W-1:0] b);
    hdr_t h;
    h.len  = b[LEN_MSB:LEN_LSB];
    h.addr = b[ADDR_MSB:ADDR_LSB];
    return h;
  endfunction
endpackage

// File: rtl/router_rd_parity.sv
// Running XOR of packet bytes; clr has priority over en, result visible the cycle after en.
// No flow control: the caller qualifies en with byte validity.
module router_rd_parity
  import router_dest_reader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] byte_dat,
  output logic [BYTE_W-1:0] parity
);
  always_ff @(posedge clock) begin
    if (reset || clr) parity <= '0;
    else if (en)      parity <= parity ^ byte_dat;
  end
endmodule

// File: rtl/router_dest_reader.sv
// Destination reader: pulls one packet from a router port FIFO and streams it out with sop/eop, checking addr and parity.
// Bytes appear 1 cycle after their read_en; sink_ready/vld_out low gate read_en in the same cycle, leaving at most one skid byte.
module router_dest_reader
  import router_dest_reader_pkg::*;
#(
  parameter logic [1:0] PORT_ID    = 2'd0,
  parameter int         START_WAIT = 0,
  parameter int         CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vld_out,
  input  logic              soft_reset,
  input  logic [BYTE_W-1:0] data_out,
  input  logic              sink_ready,
  output logic              read_en,
  output logic [BYTE_W-1:0] pkt_byte,
  output logic              pkt_byte_vld,
  output logic              pkt_sop,
  output logic              pkt_eop,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              pkt_done,
  output logic              parity_err,
  output logic              addr_err,
  output logic              abort,
  output logic [CNT_W-1:0]  pkt_count
);
  localparam logic [5:0] WAIT_INIT = 6'(START_WAIT);

  rd_state_t         state;
  logic [5:0]        wait_cnt;
  logic [LEN_W:0]    remaining;
  logic              in_flight;
  logic [ADDR_W-1:0] hdr_addr;
  logic [BYTE_W-1:0] parity;
  hdr_t              hdr;
  logic              in_pkt;
  logic              last_byte;

  assign hdr       = unpack_hdr(data_out);
  assign in_pkt    = (state == ST_WAIT) || (state == ST_HDR) || (state == ST_BODY);
  // Once the count reaches zero nothing more is requested, so the returning byte is the parity byte.
  assign last_byte = (state == ST_BODY) && (remaining == '0);

  always_comb begin
    read_en = 1'b0;
    if (!reset && !soft_reset && vld_out && sink_ready) begin
      case (state)
        ST_HDR:  read_en = !in_flight;
        ST_BODY: read_en = (remaining != '0);
        default: read_en = 1'b0;
      endcase
    end
  end

  assign pkt_byte_vld = in_flight && !soft_reset && !reset;
  assign pkt_byte     = pkt_byte_vld ? data_out : '0;
  assign pkt_sop      = pkt_byte_vld && (state == ST_HDR);
  assign pkt_eop      = pkt_byte_vld && last_byte;

  router_rd_parity u_parity (
    .clock    (clock),
    .reset    (reset),
    .clr      (state == ST_WAIT),
    .en       (pkt_byte_vld && !last_byte),
    .byte_dat (data_out),
    .parity   (parity)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      remaining  <= '0;
      in_flight  <= 1'b0;
      hdr_addr   <= '0;
      pkt_len    <= '0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      abort      <= 1'b0;
      pkt_count  <= '0;
    end else begin
      in_flight  <= read_en;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      abort      <= 1'b0;
      if (soft_reset && in_pkt) begin
        state <= ST_IDLE;
        abort <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: if (vld_out) begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_INIT;
          end
          ST_WAIT: begin
            if (wait_cnt == '0) state <= ST_HDR;
            else                wait_cnt <= wait_cnt - 1'b1;
          end
          ST_HDR: if (in_flight) begin
            remaining <= {1'b0, hdr.len} + 1'b1;
            hdr_addr  <= hdr.addr;
            pkt_len   <= hdr.len;
            state     <= ST_BODY;
          end
          ST_BODY: begin
            if (read_en) remaining <= remaining - 1'b1;
            if (pkt_eop) begin
              state      <= ST_DONE;
              pkt_done   <= 1'b1;
              parity_err <= (parity != data_out);
              addr_err   <= (hdr_addr != PORT_ID);
              pkt_count  <= pkt_count + 1'b1;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_router_dest_reader.sv
// Directed bench for router_dest_reader: a small port-FIFO model feeds the reader and a recorder logs what comes out.
`timescale 1ns/1ps
module tb_router_dest_reader;
  localparam logic [1:0] PORT = 2'd2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1, soft_reset = 1'b0, sink_ready = 1'b1, stall = 1'b0;
  logic       vld_out;
  logic [7:0] data_out = 8'hA5;
  logic       read_en, pkt_byte_vld, pkt_sop, pkt_eop, pkt_done, parity_err, addr_err, abort;
  logic [7:0] pkt_byte;
  logic [5:0] pkt_len;
  logic [15:0] pkt_count;

  logic       w_vld = 1'b0, w_soft = 1'b0;
  logic       w_read_en, w_byte_vld, w_sop, w_eop, w_done, w_perr, w_aerr, w_abort;
  logic [7:0] w_byte;
  logic [5:0] w_len;
  logic [15:0] w_count;

  router_dest_reader #(.PORT_ID(PORT), .START_WAIT(0), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .vld_out(vld_out), .soft_reset(soft_reset),
    .data_out(data_out), .sink_ready(sink_ready), .read_en(read_en), .pkt_byte(pkt_byte),
    .pkt_byte_vld(pkt_byte_vld), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_len(pkt_len),
    .pkt_done(pkt_done), .parity_err(parity_err), .addr_err(addr_err), .abort(abort),
    .pkt_count(pkt_count));

  router_dest_reader #(.PORT_ID(2'd0), .START_WAIT(35), .CNT_W(16)) dut_w (
    .clock(clock), .reset(reset), .vld_out(w_vld), .soft_reset(w_soft),
    .data_out(data_out), .sink_ready(sink_ready), .read_en(w_read_en), .pkt_byte(w_byte),
    .pkt_byte_vld(w_byte_vld), .pkt_sop(w_sop), .pkt_eop(w_eop), .pkt_len(w_len),
    .pkt_done(w_done), .parity_err(w_perr), .addr_err(w_aerr), .abort(w_abort),
    .pkt_count(w_count));

  // Port FIFO model: registered read data, vld_out means not empty (stall fakes a drained FIFO).
  logic [7:0] mem [0:255];
  logic [7:0] wr_n = 8'd0;
  logic [7:0] rd_n = 8'd0;
  assign vld_out = (wr_n != rd_n) && !stall;
  always @(posedge clock) begin
    if (read_en) begin
      data_out <= mem[rd_n];
      rd_n     <= rd_n + 8'd1;
    end
  end

  int checks = 0, failures = 0;
  int cyc = 0, rd_cnt, nb, done_cnt, abort_cnt, bad_rd, w_rd_cnt, w_abort_cnt;
  int first_rd_cyc, first_byte_cyc, eop_cyc, done_cyc, exp_n;
  logic       last_rd, last_w_rd, perr, aerr;
  logic [7:0] got [0:63];
  logic [7:0] exp [0:63];
  bit         gsop [0:63];
  bit         geop [0:63];

  task automatic clr_rec();
    rd_cnt = 0; nb = 0; done_cnt = 0; abort_cnt = 0; bad_rd = 0; w_rd_cnt = 0; w_abort_cnt = 0;
    first_rd_cyc = -1; first_byte_cyc = -1; eop_cyc = -1; done_cyc = -1;
    perr = 1'b0; aerr = 1'b0; last_rd = 1'b0; last_w_rd = 1'b0;
  endtask

  // Samples one cycle at the falling edge; the caller changes inputs after it returns.
  task automatic tick();
    @(negedge clock);
    cyc++;
    last_rd = read_en;
    last_w_rd = w_read_en;
    if (read_en) begin
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      if (!vld_out || !sink_ready) bad_rd++;
    end
    if (pkt_byte_vld) begin
      if (nb < 64) begin got[nb] = pkt_byte; gsop[nb] = pkt_sop; geop[nb] = pkt_eop; end
      if (first_byte_cyc < 0) first_byte_cyc = cyc;
      if (pkt_eop) eop_cyc = cyc;
      nb++;
    end
    if (pkt_done) begin done_cnt++; perr = parity_err; aerr = addr_err; done_cyc = cyc; end
    if (abort) abort_cnt++;
    if (w_read_en) w_rd_cnt++;
    if (w_abort) w_abort_cnt++;
    @(posedge clock);
    #1;
  endtask

  task automatic push_pkt(input logic [5:0] len, input logic [1:0] addr, input logic [7:0] base, input bit bad);
    logic [7:0] b, par, p;
    p = wr_n;
    b = {len, addr};
    mem[p] = b; exp[0] = b; par = b; p++;
    exp_n = 1;
    for (int i = 0; i < int'(len); i++) begin
      b = base + 8'(i);
      mem[p] = b; exp[exp_n] = b; exp_n++; par ^= b; p++;
    end
    if (bad) par = ~par;
    mem[p] = par; exp[exp_n] = par; exp_n++; p++;
    wr_n = p;
  endtask

  function automatic int stream_errs();
    int e = 0;
    if (nb != exp_n) e++;
    for (int i = 0; i < exp_n && i < nb; i++) begin
      if (got[i] !== exp[i]) e++;
      if (gsop[i] !== (i == 0)) e++;
      if (geop[i] !== (i == exp_n - 1)) e++;
    end
    return e;
  endfunction

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt < 1 && n < 60) begin tick(); n++; end
    checks++;
    if (done_cnt < 1) begin failures++; $display("FAIL %s_timeout: pkt_done seen %0d required 1", name, done_cnt); end
    tick();
  endtask

  task automatic wait_bytes(input int target, input string name);
    int n = 0;
    while (nb < target && n < 40) begin tick(); n++; end
    checks++;
    if (nb < target) begin failures++; $display("FAIL %s_bytes_timeout: bytes %0d required %0d", name, nb, target); end
  endtask

  task automatic test_reset();
    clr_rec();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({read_en, pkt_byte_vld, pkt_sop, pkt_eop, pkt_done, parity_err, addr_err, abort} !== 8'b0) begin
      failures++; $display("FAIL reset_flags: got %b required 00000000",
        {read_en, pkt_byte_vld, pkt_sop, pkt_eop, pkt_done, parity_err, addr_err, abort});
    end
    checks++;
    if (pkt_byte !== 8'h00) begin failures++; $display("FAIL reset_byte: got %h required 00", pkt_byte); end
    checks++;
    if ({pkt_count, pkt_len} !== 22'd0) begin failures++; $display("FAIL reset_count_len: count %0d len %0d required 0 0", pkt_count, pkt_len); end
  endtask

  task automatic test_basic();
    clr_rec();
    push_pkt(6'd3, PORT, 8'h11, 1'b0);
    wait_done("basic");
    checks++;
    if (rd_cnt !== 5) begin failures++; $display("FAIL basic_reads: got %0d required 5", rd_cnt); end
    checks++;
    if (stream_errs() !== 0) begin failures++; $display("FAIL basic_stream: %0d errors in %0d bytes, required 0 in 5", stream_errs(), nb); end
    checks++;
    if (first_byte_cyc - first_rd_cyc !== 1) begin failures++; $display("FAIL basic_latency: got %0d required 1", first_byte_cyc - first_rd_cyc); end
    checks++;
    if (done_cyc - eop_cyc !== 1) begin failures++; $display("FAIL basic_done_timing: got %0d required 1", done_cyc - eop_cyc); end
    checks++;
    if ({perr, aerr} !== 2'b00) begin failures++; $display("FAIL basic_errs: got %b required 00", {perr, aerr}); end
    checks++;
    if (pkt_count !== 16'd1 || pkt_len !== 6'd3) begin failures++; $display("FAIL basic_count_len: count %0d len %0d required 1 3", pkt_count, pkt_len); end
  endtask

  task automatic test_zero_len();
    clr_rec();
    push_pkt(6'd0, PORT, 8'h00, 1'b0);
    wait_done("zero_len");
    checks++;
    if (rd_cnt !== 2) begin failures++; $display("FAIL zero_len_reads: got %0d required 2", rd_cnt); end
    checks++;
    if (stream_errs() !== 0) begin failures++; $display("FAIL zero_len_stream: %0d errors in %0d bytes, required 0 in 2", stream_errs(), nb); end
    checks++;
    if (pkt_count !== 16'd2 || pkt_len !== 6'd0 || perr !== 1'b0) begin
      failures++; $display("FAIL zero_len_status: count %0d len %0d perr %b required 2 0 0", pkt_count, pkt_len, perr);
    end
  endtask

  task automatic test_errors();
    clr_rec();
    push_pkt(6'd2, PORT ^ 2'd1, 8'h40, 1'b1);
    wait_done("errors");
    checks++;
    if ({perr, aerr} !== 2'b11) begin failures++; $display("FAIL errors_flags: got %b required 11", {perr, aerr}); end
    checks++;
    if (pkt_count !== 16'd3 || rd_cnt !== 4) begin failures++; $display("FAIL errors_count: count %0d reads %0d required 3 4", pkt_count, rd_cnt); end
  endtask

  task automatic test_backpressure();
    int nb0;
    clr_rec();
    push_pkt(6'd6, PORT, 8'h60, 1'b0);
    wait_bytes(3, "bp");
    nb0 = nb;
    sink_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (nb - nb0 !== 1) begin failures++; $display("FAIL bp_sink_skid: got %0d bytes required 1", nb - nb0); end
    sink_ready = 1'b1;
    tick();
    stall = 1'b1;
    nb0 = nb;
    repeat (2) tick();
    checks++;
    if (nb - nb0 !== 1) begin failures++; $display("FAIL bp_empty_skid: got %0d bytes required 1", nb - nb0); end
    stall = 1'b0;
    wait_done("bp");
    checks++;
    if (bad_rd !== 0 || rd_cnt !== 8) begin failures++; $display("FAIL bp_reads: gated %0d total %0d required 0 8", bad_rd, rd_cnt); end
    checks++;
    if (stream_errs() !== 0) begin failures++; $display("FAIL bp_stream: %0d errors in %0d bytes, required 0 in 8", stream_errs(), nb); end
    checks++;
    if (pkt_count !== 16'd4 || perr !== 1'b0) begin failures++; $display("FAIL bp_status: count %0d perr %b required 4 0", pkt_count, perr); end
  endtask

  task automatic test_soft_reset_wait();
    int k = -1;
    clr_rec();
    w_vld = 1'b1;
    repeat (30) tick();
    w_soft = 1'b1;
    tick();
    w_soft = 1'b0;
    w_vld = 1'b0;
    tick();
    checks++;
    if (w_abort_cnt !== 1) begin failures++; $display("FAIL wait_abort: got %0d required 1", w_abort_cnt); end
    repeat (45) tick();
    checks++;
    if (w_rd_cnt !== 0 || w_count !== 16'd0) begin failures++; $display("FAIL wait_no_read: reads %0d count %0d required 0 0", w_rd_cnt, w_count); end
    w_vld = 1'b1;
    for (int i = 0; i < 45 && k < 0; i++) begin
      tick();
      if (last_w_rd) k = i;
    end
    checks++;
    if (k !== 37) begin failures++; $display("FAIL wait_restart_latency: got %0d required 37", k); end
    w_vld = 1'b0;
    w_soft = 1'b1;
    tick();
    w_soft = 1'b0;
    tick();
  endtask

  task automatic test_soft_reset_body();
    clr_rec();
    push_pkt(6'd5, PORT, 8'h80, 1'b0);
    wait_bytes(3, "sr");
    soft_reset = 1'b1;
    tick();
    checks++;
    if (last_rd !== 1'b0 || nb !== 3 || abort_cnt !== 0) begin
      failures++; $display("FAIL sr_same_cycle: read %b bytes %0d abort %0d required 0 3 0", last_rd, nb, abort_cnt);
    end
    soft_reset = 1'b0;
    wr_n = rd_n;
    tick();
    checks++;
    if (abort_cnt !== 1) begin failures++; $display("FAIL sr_abort: got %0d required 1", abort_cnt); end
    repeat (3) tick();
    checks++;
    if (done_cnt !== 0 || pkt_count !== 16'd4) begin failures++; $display("FAIL sr_count: done %0d count %0d required 0 4", done_cnt, pkt_count); end
    clr_rec();
    push_pkt(6'd1, PORT, 8'h90, 1'b0);
    wait_done("sr_next");
    checks++;
    if (rd_cnt !== 3 || stream_errs() !== 0) begin failures++; $display("FAIL sr_next_stream: reads %0d errors %0d required 3 0", rd_cnt, stream_errs()); end
    checks++;
    if (pkt_count !== 16'd5 || perr !== 1'b0) begin failures++; $display("FAIL sr_next_status: count %0d perr %b required 5 0", pkt_count, perr); end
  endtask

  task automatic test_reset_mid();
    clr_rec();
    push_pkt(6'd4, PORT, 8'hA0, 1'b0);
    wait_bytes(2, "rm");
    reset = 1'b1;
    wr_n = rd_n;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    checks++;
    if (abort_cnt !== 0 || done_cnt !== 0) begin failures++; $display("FAIL rm_pulses: abort %0d done %0d required 0 0", abort_cnt, done_cnt); end
    checks++;
    if (pkt_count !== 16'd0 || pkt_len !== 6'd0) begin failures++; $display("FAIL rm_state: count %0d len %0d required 0 0", pkt_count, pkt_len); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_errors();
    test_backpressure();
    test_soft_reset_wait();
    test_soft_reset_body();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
